// File: rtl/ultrasonic_scanner.sv
// rtl/ultrasonic_scanner.sv - multiplexed ultrasonic ranging scanner
// Walks the sensor mux, fires a trigger, times the echo in cm and reports one result per sensor.
module ultrasonic_scanner #(
  parameter int NUM_SENSORS    = 4,
  parameter int SETTLE_CYCLES  = 500,
  parameter int TRIG_CYCLES    = 500,
  parameter int CM_CYCLES      = 2900,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int GAP_CYCLES     = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_enable,
  input  logic        echo_rx,
  output logic        trig_tx,
  output logic [3:0]  mux_sensor_select,
  output logic        dist_valid,
  output logic [3:0]  dist_sensor,
  output logic [15:0] distance,
  output logic        dist_timeout
);

  localparam int MAX_A   = (SETTLE_CYCLES > TRIG_CYCLES) ? SETTLE_CYCLES : TRIG_CYCLES;
  localparam int MAX_B   = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int PW      = (CM_CYCLES > 1) ? $clog2(CM_CYCLES) : 1;

  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TRIG_LAST    = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] CM_LAST      = PW'(CM_CYCLES - 1);
  localparam logic [3:0]    IDX_LAST     = 4'(NUM_SENSORS - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, TRIG, WAIT_RISE, MEASURE, REPORT, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   dcnt_q, dcnt_d;
  logic [3:0]    idx_q, idx_d;
  logic          trig_q, trig_d;
  logic          dist_valid_q, dist_valid_d;
  logic [3:0]    dist_sensor_q, dist_sensor_d;
  logic [15:0]   distance_q, distance_d;
  logic          dist_timeout_q, dist_timeout_d;
  logic          echo_s1_q, echo_s1_d, echo_s2_q, echo_s2_d, echo_prev_q, echo_prev_d;
  logic          echo_rise, echo_fall;
  logic          report_go, report_to, abort;

  assign echo_rise = echo_s2_q & ~echo_prev_q;
  assign echo_fall = ~echo_s2_q & echo_prev_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pre_d          = pre_q;
    dcnt_d         = dcnt_q;
    idx_d          = idx_q;
    trig_d         = trig_q;
    dist_valid_d   = 1'b0;
    dist_sensor_d  = dist_sensor_q;
    distance_d     = distance_q;
    dist_timeout_d = dist_timeout_q;
    echo_s1_d      = echo_rx;
    echo_s2_d      = echo_s1_q;
    echo_prev_d    = echo_s2_q;
    report_go      = 1'b0;
    report_to      = 1'b0;
    abort          = 1'b0;

    case (state_q)
      IDLE: begin
        trig_d = 1'b0;
        cnt_d  = '0;
        if (scan_enable) state_d = SETTLE;
      end
      SETTLE: begin
        if (!scan_enable) abort = 1'b1;
        else if (cnt_q == SETTLE_LAST) begin
          state_d = TRIG;
          cnt_d   = '0;
          trig_d  = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      end
      TRIG: begin
        if (!scan_enable) abort = 1'b1;
        else if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
          trig_d  = 1'b0;
        end else cnt_d = cnt_q + CW'(1);
      end
      WAIT_RISE: begin
        if (!scan_enable) abort = 1'b1;
        else if (echo_rise) begin
          state_d = MEASURE;
          cnt_d   = '0;
          pre_d   = '0;
          dcnt_d  = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          report_go = 1'b1;
          report_to = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      end
      MEASURE: begin
        // Falling edge wins over a simultaneous timeout so a real echo is never lost.
        if (!scan_enable) abort = 1'b1;
        else if (echo_fall) report_go = 1'b1;
        else if (cnt_q == TIMEOUT_LAST) begin
          report_go = 1'b1;
          report_to = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (pre_q == CM_LAST) begin
            pre_d = '0;
            if (dcnt_q != 16'hFFFF) dcnt_d = dcnt_q + 16'd1;
          end else pre_d = pre_q + PW'(1);
        end
      end
      REPORT: begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? 4'd0 : idx_q + 4'd1;
          state_d = scan_enable ? SETTLE : IDLE;
        end else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (report_go) begin
      state_d        = REPORT;
      cnt_d          = '0;
      dist_valid_d   = 1'b1;
      dist_sensor_d  = idx_q;
      distance_d     = report_to ? 16'hFFFF : dcnt_q;
      dist_timeout_d = report_to;
    end

    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      pre_d   = '0;
      dcnt_d  = '0;
      trig_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      pre_q          <= '0;
      dcnt_q         <= '0;
      idx_q          <= '0;
      trig_q         <= 1'b0;
      dist_valid_q   <= 1'b0;
      dist_sensor_q  <= '0;
      distance_q     <= '0;
      dist_timeout_q <= 1'b0;
      echo_s1_q      <= 1'b0;
      echo_s2_q      <= 1'b0;
      echo_prev_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pre_q          <= pre_d;
      dcnt_q         <= dcnt_d;
      idx_q          <= idx_d;
      trig_q         <= trig_d;
      dist_valid_q   <= dist_valid_d;
      dist_sensor_q  <= dist_sensor_d;
      distance_q     <= distance_d;
      dist_timeout_q <= dist_timeout_d;
      echo_s1_q      <= echo_s1_d;
      echo_s2_q      <= echo_s2_d;
      echo_prev_q    <= echo_prev_d;
    end
  end

  assign trig_tx           = trig_q;
  assign mux_sensor_select = idx_q;
  assign dist_valid        = dist_valid_q;
  assign dist_sensor       = dist_sensor_q;
  assign distance          = distance_q;
  assign dist_timeout      = dist_timeout_q;

endmodule

// File: tb/tb_ultrasonic_scanner.sv
// tb/tb_ultrasonic_scanner.sv - scoreboard bench for ultrasonic_scanner
// Stimulus pushes expected results; a negedge monitor pops them on every dist_valid.
module tb_ultrasonic_scanner;

  localparam int NS = 3, SETTLE = 4, TRIG = 5, CM = 10, TMO = 200, GAP = 8;

  logic        clk = 1'b0;
  logic        reset, scan_enable, echo_rx;
  logic        trig_tx, dist_valid, dist_timeout;
  logic [3:0]  mux_sensor_select, dist_sensor;
  logic [15:0] distance;

  typedef struct {
    logic [3:0]  s;
    logic [15:0] d;
    logic        to;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pulses = 0;
  int   n_pushed = 0;

  ultrasonic_scanner #(
    .NUM_SENSORS(NS), .SETTLE_CYCLES(SETTLE), .TRIG_CYCLES(TRIG),
    .CM_CYCLES(CM), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset), .scan_enable(scan_enable), .echo_rx(echo_rx),
    .trig_tx(trig_tx), .mux_sensor_select(mux_sensor_select),
    .dist_valid(dist_valid), .dist_sensor(dist_sensor),
    .distance(distance), .dist_timeout(dist_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && dist_valid === 1'b1) begin
      n_pulses++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_dist_valid: got sensor %0d distance %0h, expected no result",
                 dist_sensor, distance);
      end else begin
        mon_e = sb.pop_front();
        chk("dist_sensor", dist_sensor, mon_e.s);
        chk("distance", distance, mon_e.d);
        chk("dist_timeout", dist_timeout, mon_e.to);
      end
    end
  end

  task automatic wait_trig();
    int k = 0;
    while (trig_tx !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL trig_wait: trig_tx got %0b, expected 1 within 2000 cycles", trig_tx);
    end
  endtask

  task automatic wait_sb_empty(input int bound);
    int k = 0;
    while (sb.size() != 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (k >= bound) begin
      n_cmp++;
      n_bad++;
      $display("FAIL result_wait: got %0d pending results, expected 0", sb.size());
    end
  endtask

  // h > 0: echo pulse of h clocks; h == 0: no echo; h < 0: echo held high.
  task automatic run_scan(input int idx, input int h, input bit push,
                          input logic [15:0] ed, input logic eto);
    exp_t t;
    int   w;
    if (push) begin
      t.s  = 4'(idx);
      t.d  = ed;
      t.to = eto;
      sb.push_back(t);
      n_pushed++;
    end
    wait_trig();
    chk("mux_at_trig", mux_sensor_select, idx);
    w = 0;
    while (trig_tx === 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("trig_width", w, TRIG);
    if (h != 0) begin
      repeat (3) @(posedge clk);
      #1 echo_rx = 1'b1;
      if (h > 0) begin
        repeat (h) @(posedge clk);
        #1 echo_rx = 1'b0;
      end
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_trig"}, trig_tx, 0);
    chk({tag, "_mux"}, mux_sensor_select, 0);
    chk({tag, "_valid"}, dist_valid, 0);
    chk({tag, "_sensor"}, dist_sensor, 0);
    chk({tag, "_distance"}, distance, 0);
    chk({tag, "_timeout"}, dist_timeout, 0);
  endtask

  initial begin
    reset = 1'b1;
    scan_enable = 1'b0;
    echo_rx = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    scan_enable = 1'b1;

    // Continuous scan across all three sensors and wrap back to sensor 0.
    run_scan(0, 57, 1, 16'd5, 1'b0);
    run_scan(1, 0, 1, 16'hFFFF, 1'b1);
    run_scan(2, 23, 1, 16'd2, 1'b0);
    run_scan(0, -1, 1, 16'hFFFF, 1'b1);
    wait_sb_empty(600);
    @(posedge clk);
    #1 scan_enable = 1'b0;
    echo_rx = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_mux", mux_sensor_select, 1);
    chk("idle_trig", trig_tx, 0);

    // Drop scan_enable mid-measurement: no result, outputs untouched.
    @(posedge clk);
    #1 scan_enable = 1'b1;
    run_scan(1, -1, 0, 16'd0, 1'b0);
    repeat (30) @(posedge clk);
    #1 scan_enable = 1'b0;
    repeat (250) @(negedge clk);
    chk("abort_mux", mux_sensor_select, 1);
    chk("abort_trig", trig_tx, 0);
    chk("abort_sensor", dist_sensor, 0);
    chk("abort_distance", distance, 16'hFFFF);
    chk("abort_timeout", dist_timeout, 1);
    echo_rx = 1'b0;

    // Reset during trigger pulse, then restart at sensor 0 with fall on the timeout cycle.
    @(posedge clk);
    #1 scan_enable = 1'b1;
    wait_trig();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_zero_outputs("midtrig_reset");
    run_scan(0, 200, 1, 16'd19, 1'b0);
    wait_sb_empty(600);
    repeat (5) @(negedge clk);
    chk("dist_valid_count", n_pulses, n_pushed);
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation got stuck, expected completion");
    $fatal(1);
  end

endmodule
